// File: rtl/cont_bank.sv
// Bank of N independent up/down/load counters with per-channel enable, clear,
// wrap-or-saturate limits and a registered terminal-count pulse.
module cont_bank #(
    parameter int          N        = 2,
    parameter int          WIDTH    = 6,
    parameter int unsigned MAX_VAL  = 63,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N-1:0]         ch_clr,
    input  logic [N-1:0]         en,
    input  logic [2*N-1:0]       operacao,
    input  logic [N*WIDTH-1:0]   valor,
    output logic [N*WIDTH-1:0]   cont,
    output logic [N-1:0]         tc
);

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q [N];
    logic [WIDTH-1:0] cnt_d [N];
    logic [N-1:0]     tc_q;
    logic [N-1:0]     tc_d;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            logic [WIDTH-1:0] ld;
            cnt_d[i] = cnt_q[i];
            tc_d[i]  = 1'b0;
            ld       = valor[WIDTH*i +: WIDTH];
            if (ch_clr[i]) begin
                cnt_d[i] = '0;
            end else if (en[i]) begin
                case (op_t'(operacao[2*i +: 2]))
                    OP_INC: begin
                        if (cnt_q[i] == MAXV) begin
                            tc_d[i]  = 1'b1;
                            cnt_d[i] = SATURATE ? MAXV : '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    OP_DEC: begin
                        if (cnt_q[i] == '0) begin
                            tc_d[i]  = 1'b1;
                            cnt_d[i] = SATURATE ? '0 : MAXV;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end
                    end
                    OP_LOAD: cnt_d[i] = (ld > MAXV) ? MAXV : ld;
                    default: cnt_d[i] = cnt_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
            tc_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            tc_q <= tc_d;
        end
    end

    always_comb begin
        cont = '0;
        for (int unsigned i = 0; i < N; i++) cont[WIDTH*i +: WIDTH] = cnt_q[i];
    end

    assign tc = tc_q;

endmodule

// File: tb/tb_cont_bank.sv
// Self-checking bench: three cont_bank variants (wrap/63, wrap/9, saturate/63)
// share one stimulus stream; directed scenarios plus a randomized model check.
module tb_cont_bank;

    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  ch_clr;
    logic [1:0]  en;
    logic [3:0]  operacao;
    logic [11:0] valor;
    logic [11:0] cont0, cont9, conts;
    logic [1:0]  tc0, tc9, tcs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cont_bank #(.N(2), .WIDTH(6), .MAX_VAL(63), .SATURATE(1'b0)) u0 (
        .clk(clk), .clr(clr), .ch_clr(ch_clr), .en(en),
        .operacao(operacao), .valor(valor), .cont(cont0), .tc(tc0));

    cont_bank #(.N(2), .WIDTH(6), .MAX_VAL(9), .SATURATE(1'b0)) u9 (
        .clk(clk), .clr(clr), .ch_clr(ch_clr), .en(en),
        .operacao(operacao), .valor(valor), .cont(cont9), .tc(tc9));

    cont_bank #(.N(2), .WIDTH(6), .MAX_VAL(63), .SATURATE(1'b1)) us (
        .clk(clk), .clr(clr), .ch_clr(ch_clr), .en(en),
        .operacao(operacao), .valor(valor), .cont(conts), .tc(tcs));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; ch_clr = 2'b00; en = 2'b11; operacao = 4'b0101; valor = '0;
        tick();
        tests++;
        if (cont0 !== 12'd0 || tc0 !== 2'b00) begin
            fails++; $display("FAIL reset_u0 cont=%h tc=%b want 000 00", cont0, tc0);
        end
        tests++;
        if (cont9 !== 12'd0 || conts !== 12'd0 || tc9 !== 2'b00 || tcs !== 2'b00) begin
            fails++; $display("FAIL reset_others cont9=%h conts=%h tc9=%b tcs=%b want 0", cont9, conts, tc9, tcs);
        end
        clr = 1'b0;
        repeat (3) tick();
        tests++;
        if (cont0 !== {6'd3, 6'd3} || tc0 !== 2'b00) begin
            fails++; $display("FAIL count3 cont=%h tc=%b want %h 00", cont0, tc0, {6'd3, 6'd3});
        end
    endtask

    task automatic test_wrap_up();
        en = 2'b11; operacao = 4'b0011; valor = {6'd0, 6'd62};
        tick();
        operacao = 4'b0001;
        tick();
        tests++;
        if (cont0[5:0] !== 6'd63 || tc0[0] !== 1'b0) begin
            fails++; $display("FAIL wrapup_63 cont=%0d tc=%b want 63 0", cont0[5:0], tc0[0]);
        end
        tick();
        tests++;
        if (cont0[5:0] !== 6'd0 || tc0[0] !== 1'b1) begin
            fails++; $display("FAIL wrapup_0 cont=%0d tc=%b want 0 1", cont0[5:0], tc0[0]);
        end
        operacao = 4'b0000;
        tick();
        tests++;
        if (cont0[5:0] !== 6'd0 || tc0[0] !== 1'b0) begin
            fails++; $display("FAIL wrapup_pulse cont=%0d tc=%b want 0 0", cont0[5:0], tc0[0]);
        end
    endtask

    task automatic test_wrap_down_clamp();
        en = 2'b11; operacao = 4'b0011; valor = {6'd0, 6'd12};
        tick();
        tests++;
        if (cont9[5:0] !== 6'd9 || tc9[0] !== 1'b0 || cont0[5:0] !== 6'd12) begin
            fails++; $display("FAIL clamp cont9=%0d tc9=%b cont0=%0d want 9 0 12", cont9[5:0], tc9[0], cont0[5:0]);
        end
        valor = '0;
        tick();
        operacao = 4'b0010;
        tick();
        tests++;
        if (cont9[5:0] !== 6'd9 || tc9[0] !== 1'b1) begin
            fails++; $display("FAIL wrapdown cont=%0d tc=%b want 9 1", cont9[5:0], tc9[0]);
        end
        tests++;
        if (cont0[5:0] !== 6'd63 || tc0[0] !== 1'b1) begin
            fails++; $display("FAIL wrapdown63 cont=%0d tc=%b want 63 1", cont0[5:0], tc0[0]);
        end
        tick();
        tests++;
        if (cont9[5:0] !== 6'd8 || tc9[0] !== 1'b0) begin
            fails++; $display("FAIL wrapdown_next cont=%0d tc=%b want 8 0", cont9[5:0], tc9[0]);
        end
    endtask

    task automatic test_saturate();
        en = 2'b11; operacao = 4'b0011; valor = {6'd0, 6'd63};
        tick();
        operacao = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (conts[5:0] !== 6'd63 || tcs[0] !== 1'b1) begin
                fails++; $display("FAIL sat_hi[%0d] cont=%0d tc=%b want 63 1", k, conts[5:0], tcs[0]);
            end
        end
        operacao = 4'b0011; valor = '0;
        tick();
        operacao = 4'b0010;
        tick();
        tests++;
        if (conts[5:0] !== 6'd0 || tcs[0] !== 1'b1) begin
            fails++; $display("FAIL sat_lo cont=%0d tc=%b want 0 1", conts[5:0], tcs[0]);
        end
    endtask

    task automatic test_priority();
        ch_clr = 2'b00; en = 2'b11; operacao = 4'b1100; valor = {6'd5, 6'd0};
        tick();
        ch_clr = 2'b01; operacao = 4'b0101;
        tick();
        tests++;
        if (cont0 !== {6'd6, 6'd0} || tc0 !== 2'b00) begin
            fails++; $display("FAIL chclr cont=%h tc=%b want %h 00", cont0, tc0, {6'd6, 6'd0});
        end
        ch_clr = 2'b00;
        repeat (2) tick();
        en = 2'b10;
        tick();
        tests++;
        if (cont0 !== {6'd9, 6'd2} || tc0 !== 2'b00) begin
            fails++; $display("FAIL en_hold cont=%h tc=%b want %h 00", cont0, tc0, {6'd9, 6'd2});
        end
        en = 2'b11; operacao = 4'b0010; valor = '0;
        tick(); tick(); tick();
        en = 2'b10; operacao = 4'b0000;
        tick();
        tests++;
        if (cont0[5:0] !== 6'd63 || tc0[0] !== 1'b0) begin
            fails++; $display("FAIL en_clears_tc cont=%0d tc=%b want 63 0", cont0[5:0], tc0[0]);
        end
    endtask

    task automatic test_reset_mid();
        ch_clr = 2'b00; en = 2'b11; operacao = 4'b0011; valor = {6'd0, 6'd39};
        tick();
        operacao = 4'b0001;
        tick();
        tests++;
        if (cont0[5:0] !== 6'd40) begin
            fails++; $display("FAIL mid_setup cont=%0d want 40", cont0[5:0]);
        end
        clr = 1'b1; operacao = 4'b0011; valor = {6'd0, 6'd20};
        tick();
        tests++;
        if (cont0 !== 12'd0 || tc0 !== 2'b00) begin
            fails++; $display("FAIL mid_clr cont=%h tc=%b want 000 00", cont0, tc0);
        end
        clr = 1'b0; operacao = 4'b0001;
        tick();
        tests++;
        if (cont0[5:0] !== 6'd1) begin
            fails++; $display("FAIL mid_resume cont=%0d want 1", cont0[5:0]);
        end
    endtask

    task automatic test_random();
        int mc [3][2];
        int mt [3][2];
        int mx [3] = '{63, 9, 63};
        bit sat [3] = '{1'b0, 1'b0, 1'b1};
        clr = 1'b1; ch_clr = '0; en = '0; operacao = '0; valor = '0;
        tick();
        foreach (mc[k, i]) begin mc[k][i] = 0; mt[k][i] = 0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            clr = ($urandom_range(39) == 0);
            ch_clr[0] = ($urandom_range(9) == 0);
            ch_clr[1] = ($urandom_range(9) == 0);
            en[0] = ($urandom_range(4) != 0);
            en[1] = ($urandom_range(4) != 0);
            operacao = 4'($urandom);
            for (int i = 0; i < 2; i++)
                valor[6*i +: 6] = ($urandom_range(3) == 0) ? 6'(62 + $urandom_range(1)) : 6'($urandom);
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 2; i++) begin
                    int c, v, op;
                    c = mc[k][i];
                    op = int'(operacao[2*i +: 2]);
                    v = int'(valor[6*i +: 6]);
                    mt[k][i] = 0;
                    if (clr || ch_clr[i]) c = 0;
                    else if (en[i]) begin
                        if (op == 1) begin
                            mt[k][i] = (c == mx[k]);
                            c = sat[k] ? ((c < mx[k]) ? c + 1 : mx[k]) : (c + 1) % (mx[k] + 1);
                        end else if (op == 2) begin
                            mt[k][i] = (c == 0);
                            c = sat[k] ? ((c > 0) ? c - 1 : 0) : (c + mx[k]) % (mx[k] + 1);
                        end else if (op == 3) begin
                            c = (v > mx[k]) ? mx[k] : v;
                        end
                    end
                    mc[k][i] = c;
                end
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                logic [11:0] oc;
                logic [1:0]  ot;
                oc = (k == 0) ? cont0 : (k == 1) ? cont9 : conts;
                ot = (k == 0) ? tc0 : (k == 1) ? tc9 : tcs;
                for (int i = 0; i < 2; i++) begin
                    tests++;
                    if (oc[6*i +: 6] !== 6'(mc[k][i]) || ot[i] !== 1'(mt[k][i])) begin
                        fails++;
                        $display("FAIL rand cyc=%0d inst=%0d ch=%0d cont=%0d tc=%b want %0d %0d",
                                 cyc, k, i, oc[6*i +: 6], ot[i], mc[k][i], mt[k][i]);
                    end
                end
            end
        end
    endtask

    initial begin
        clr = 1'b0; ch_clr = '0; en = '0; operacao = '0; valor = '0;
        test_reset();
        test_wrap_up();
        test_wrap_down_clamp();
        test_saturate();
        test_priority();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
